// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, FSM state types and a small counter helper
// shared by the VGA timing controller.
package vga_timing_pkg;

  localparam int DEF_DIV      = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START   = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START   = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC, H_BACK} hstate_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC, V_BACK} vstate_t;

  // Increment with wrap to zero after the last legal value.
  function automatic logic [9:0] wrap_inc(input logic [9:0] val, input logic [9:0] last);
    return (val == last) ? 10'd0 : val + 10'd1;
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate strobe generator: a 0..DIV-1 counter that is cleared while enable is low.
module pix_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic enable,
  output logic pix_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divider counter; held at zero while the raster is idle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign pix_tick = enable && (r_cnt == C_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel/line counters, horizontal and vertical phase FSMs, and
// registered sync/blanking/start strobes that change on the same edge as the counts.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       enable,
  output logic       pix_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic       w_tick;
  logic [9:0] r_hcount, w_hcount_nxt;
  logic [9:0] r_vcount, w_vcount_nxt;
  hstate_t    r_hstate, w_hstate_nxt;
  vstate_t    r_vstate, w_vstate_nxt;
  logic       r_running, w_running_nxt;
  logic       r_pix_tick, r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;
  logic       w_line_nxt, w_frame_nxt, w_hsync_nxt, w_vsync_nxt, w_video_nxt;

  pix_tick_gen #(.DIV(DIV)) u_pix_tick_gen (
    .clk_in   (clk_in),
    .rst      (rst),
    .enable   (enable),
    .pix_tick (w_tick)
  );

  // Next raster position, phase states and strobes. The first tick after idle
  // only arms the raster at 0/0 so that it emits both start pulses.
  always_comb begin
    w_hcount_nxt  = r_hcount;
    w_vcount_nxt  = r_vcount;
    w_hstate_nxt  = r_hstate;
    w_vstate_nxt  = r_vstate;
    w_running_nxt = r_running;
    w_line_nxt    = 1'b0;
    w_frame_nxt   = 1'b0;
    if (!enable) begin
      w_hcount_nxt  = 10'd0;
      w_vcount_nxt  = 10'd0;
      w_hstate_nxt  = H_ACT;
      w_vstate_nxt  = V_ACT;
      w_running_nxt = 1'b0;
    end else if (w_tick && !r_running) begin
      w_hcount_nxt  = 10'd0;
      w_vcount_nxt  = 10'd0;
      w_hstate_nxt  = H_ACT;
      w_vstate_nxt  = V_ACT;
      w_running_nxt = 1'b1;
      w_line_nxt    = 1'b1;
      w_frame_nxt   = 1'b1;
    end else if (w_tick) begin
      w_hcount_nxt = wrap_inc(r_hcount, H_LAST);
      case (r_hstate)
        H_ACT:                  w_hstate_nxt = (r_hcount == H_ACT_LAST)  ? H_FRONT : H_ACT;
        H_FRONT:                w_hstate_nxt = (r_hcount == H_FP_LAST)   ? vga_timing_pkg::H_SYNC : H_FRONT;
        vga_timing_pkg::H_SYNC: w_hstate_nxt = (r_hcount == H_SYNC_LAST) ? H_BACK : vga_timing_pkg::H_SYNC;
        H_BACK:                 w_hstate_nxt = (r_hcount == H_LAST)      ? H_ACT : H_BACK;
        default:                w_hstate_nxt = H_ACT;
      endcase
      if (r_hcount == H_LAST) begin
        w_line_nxt   = 1'b1;
        w_frame_nxt  = (r_vcount == V_LAST);
        w_vcount_nxt = wrap_inc(r_vcount, V_LAST);
        case (r_vstate)
          V_ACT:                  w_vstate_nxt = (r_vcount == V_ACT_LAST)  ? V_FRONT : V_ACT;
          V_FRONT:                w_vstate_nxt = (r_vcount == V_FP_LAST)   ? vga_timing_pkg::V_SYNC : V_FRONT;
          vga_timing_pkg::V_SYNC: w_vstate_nxt = (r_vcount == V_SYNC_LAST) ? V_BACK : vga_timing_pkg::V_SYNC;
          V_BACK:                 w_vstate_nxt = (r_vcount == V_LAST)      ? V_ACT : V_BACK;
          default:                w_vstate_nxt = V_ACT;
        endcase
      end else begin
        w_vcount_nxt = r_vcount;
      end
    end else begin
      w_running_nxt = r_running;
    end
    w_hsync_nxt = (w_hstate_nxt != vga_timing_pkg::H_SYNC);
    w_vsync_nxt = (w_vstate_nxt != vga_timing_pkg::V_SYNC);
    w_video_nxt = w_running_nxt && (w_hstate_nxt == H_ACT) && (w_vstate_nxt == V_ACT);
  end

  // State and output registers, all updated together.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_hcount      <= 10'd0;
      r_vcount      <= 10'd0;
      r_hstate      <= H_ACT;
      r_vstate      <= V_ACT;
      r_running     <= 1'b0;
      r_pix_tick    <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hstate      <= w_hstate_nxt;
      r_vstate      <= w_vstate_nxt;
      r_running     <= w_running_nxt;
      r_pix_tick    <= w_tick;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_video_on    <= w_video_nxt;
      r_line_start  <= w_line_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

  assign pix_tick    = r_pix_tick;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: a default-timing instance (A) and a tiny
// DIV=2, 14x7 raster instance (B) for frame-level and async-reset scenarios.
module tb_vga_timing_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_a, en_a, rst_b, en_b;
  logic       tick_a, hs_a, vs_a, vid_a, ls_a, fs_a;
  logic       tick_b, hs_b, vs_b, vid_b, ls_b, fs_b;
  logic [9:0] hc_a, vc_a, hc_b, vc_b;
  logic [5:0] flags_a, flags_b;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Flag order: {pix_tick, line_start, frame_start, hsync, vsync, video_on}
  assign flags_a = {tick_a, ls_a, fs_a, hs_a, vs_a, vid_a};
  assign flags_b = {tick_b, ls_b, fs_b, hs_b, vs_b, vid_b};

  vga_timing_ctrl u_dut_a (
    .clk_in(clk_in), .rst(rst_a), .enable(en_a), .pix_tick(tick_a),
    .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(vid_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_ctrl #(
    .DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_b (
    .clk_in(clk_in), .rst(rst_b), .enable(en_b), .pix_tick(tick_b),
    .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(vid_b), .line_start(ls_b), .frame_start(fs_b)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    repeat (3) step();
    n_checks++; if (flags_a !== 6'b000110) begin n_fail++; $display("FAIL reset_flags_a: got %b expected %b", flags_a, 6'b000110); end
    n_checks++; if (hc_a !== 10'd0 || vc_a !== 10'd0) begin n_fail++; $display("FAIL reset_counts_a: got h=%0d v=%0d expected 0/0", hc_a, vc_a); end
    n_checks++; if (flags_b !== 6'b000110) begin n_fail++; $display("FAIL reset_flags_b: got %b expected %b", flags_b, 6'b000110); end
    n_checks++; if (hc_b !== 10'd0 || vc_b !== 10'd0) begin n_fail++; $display("FAIL reset_counts_b: got h=%0d v=%0d expected 0/0", hc_b, vc_b); end
  endtask

  task automatic test_first_tick();
    rst_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++; if (tick_a !== 1'b0) begin n_fail++; $display("FAIL early_tick_a: cycle %0d got %b expected 0", i, tick_a); end
    end
    step();
    n_checks++; if (flags_a !== 6'b111111) begin n_fail++; $display("FAIL first_tick_flags_a: got %b expected %b", flags_a, 6'b111111); end
    n_checks++; if (hc_a !== 10'd0 || vc_a !== 10'd0) begin n_fail++; $display("FAIL first_tick_counts_a: got h=%0d v=%0d expected 0/0", hc_a, vc_a); end
  endtask

  task automatic test_line();
    int h_bad = 0, v_bad = 0, vid_bad = 0, tick_cnt = 0, hs_low = 0;
    int first_low_h = -1, ls_cnt = 0, ls_k = -1, max_h = 0;
    for (int k = 1; k <= 3200; k++) begin
      int exp_h, exp_v;
      step();
      exp_h = (k / 4) % 800;
      exp_v = k / 3200;
      if (hc_a !== 10'(exp_h)) h_bad++;
      if (vc_a !== 10'(exp_v)) v_bad++;
      if (vid_a !== (exp_h < 640)) vid_bad++;
      if (tick_a === 1'b1) tick_cnt++;
      if (hs_a === 1'b0) begin
        hs_low++;
        if (first_low_h < 0) first_low_h = int'(hc_a);
      end
      if (ls_a === 1'b1) begin ls_cnt++; ls_k = k; end
      if (int'(hc_a) > max_h) max_h = int'(hc_a);
    end
    n_checks++; if (h_bad != 0)       begin n_fail++; $display("FAIL line_hcount: got %0d bad cycles expected 0", h_bad); end
    n_checks++; if (v_bad != 0)       begin n_fail++; $display("FAIL line_vcount: got %0d bad cycles expected 0", v_bad); end
    n_checks++; if (vid_bad != 0)     begin n_fail++; $display("FAIL line_video_on: got %0d bad cycles expected 0", vid_bad); end
    n_checks++; if (tick_cnt != 800) begin n_fail++; $display("FAIL line_ticks: got %0d expected 800", tick_cnt); end
    n_checks++; if (hs_low != 384)    begin n_fail++; $display("FAIL hsync_width: got %0d clk expected 384", hs_low); end
    n_checks++; if (first_low_h != 656) begin n_fail++; $display("FAIL hsync_start: got h=%0d expected 656", first_low_h); end
    n_checks++; if (ls_cnt != 1 || ls_k != 3200) begin n_fail++; $display("FAIL line_period: got %0d pulses last at %0d expected 1 at 3200", ls_cnt, ls_k); end
    n_checks++; if (max_h != 799)     begin n_fail++; $display("FAIL hcount_max: got %0d expected 799", max_h); end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 2000 && hc_a !== 10'd300; i++) step();
    n_checks++; if (hc_a !== 10'd300 || vc_a !== 10'd1) begin n_fail++; $display("FAIL reach_h300: got h=%0d v=%0d expected 300/1", hc_a, vc_a); end
    en_a = 1'b0;
    step();
    n_checks++; if (flags_a !== 6'b000110) begin n_fail++; $display("FAIL drop_flags: got %b expected %b", flags_a, 6'b000110); end
    n_checks++; if (hc_a !== 10'd0 || vc_a !== 10'd0) begin n_fail++; $display("FAIL drop_counts: got h=%0d v=%0d expected 0/0", hc_a, vc_a); end
    repeat (5) step();
    n_checks++; if (flags_a !== 6'b000110 || hc_a !== 10'd0) begin n_fail++; $display("FAIL idle_hold: got %b h=%0d expected %b h=0", flags_a, hc_a, 6'b000110); end
    en_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++; if (flags_a !== 6'b000110) begin n_fail++; $display("FAIL reenable_wait: cycle %0d got %b expected %b", i, flags_a, 6'b000110); end
    end
    step();
    n_checks++; if (flags_a !== 6'b111111) begin n_fail++; $display("FAIL reenable_start: got %b expected %b", flags_a, 6'b111111); end
  endtask

  task automatic test_small_frame();
    int flag_bad = 0, pos_bad = 0, hs_low = 0, vs_low = 0, fs_cnt = 0, bad_k = -1;
    logic [5:0] bad_got, bad_exp;
    bad_got = 6'd0; bad_exp = 6'd0;
    rst_b = 1'b0;
    step();
    n_checks++; if (tick_b !== 1'b0) begin n_fail++; $display("FAIL small_early_tick: got %b expected 0", tick_b); end
    step();
    n_checks++; if (flags_b !== 6'b111111 || hc_b !== 10'd0 || vc_b !== 10'd0) begin n_fail++; $display("FAIL small_first_tick: got %b h=%0d v=%0d expected %b 0/0", flags_b, hc_b, vc_b, 6'b111111); end
    for (int k = 1; k <= 196; k++) begin
      int t, eh, ev;
      logic et, els;
      logic [5:0] ef;
      step();
      t   = k / 2;
      eh  = t % 14;
      ev  = (t / 14) % 7;
      et  = (k % 2 == 0);
      els = et && (eh == 0);
      ef  = {et, els, els && (ev == 0), !(eh >= 10 && eh <= 11), (ev != 5), (eh < 8) && (ev < 4)};
      if (flags_b !== ef) begin
        flag_bad++;
        if (bad_k < 0) begin bad_k = k; bad_got = flags_b; bad_exp = ef; end
      end
      if (hc_b !== 10'(eh) || vc_b !== 10'(ev)) pos_bad++;
      if (hs_b === 1'b0) hs_low++;
      if (vs_b === 1'b0) vs_low++;
      if (fs_b === 1'b1) fs_cnt++;
    end
    n_checks++; if (flag_bad != 0) begin n_fail++; $display("FAIL small_flags: %0d bad cycles, first k=%0d got %b expected %b", flag_bad, bad_k, bad_got, bad_exp); end
    n_checks++; if (pos_bad != 0)  begin n_fail++; $display("FAIL small_counts: got %0d bad cycles expected 0", pos_bad); end
    n_checks++; if (hs_low != 28)  begin n_fail++; $display("FAIL small_hsync_low: got %0d expected 28", hs_low); end
    n_checks++; if (vs_low != 28)  begin n_fail++; $display("FAIL small_vsync_low: got %0d expected 28", vs_low); end
    n_checks++; if (fs_cnt != 1)   begin n_fail++; $display("FAIL small_frame_period: got %0d pulses expected 1", fs_cnt); end
    n_checks++; if (ls_b !== 1'b1 || fs_b !== 1'b1) begin n_fail++; $display("FAIL double_wrap: got ls=%b fs=%b expected 1/1", ls_b, fs_b); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 200 && !(vc_b === 10'd5 && hc_b === 10'd3); i++) step();
    n_checks++; if (vc_b !== 10'd5 || hc_b !== 10'd3 || vs_b !== 1'b0) begin n_fail++; $display("FAIL reach_vsync: got h=%0d v=%0d vsync=%b expected 3/5/0", hc_b, vc_b, vs_b); end
    #3;
    rst_b = 1'b1;
    #1;
    n_checks++; if (flags_b !== 6'b000110) begin n_fail++; $display("FAIL async_rst_flags: got %b expected %b", flags_b, 6'b000110); end
    n_checks++; if (hc_b !== 10'd0 || vc_b !== 10'd0) begin n_fail++; $display("FAIL async_rst_counts: got h=%0d v=%0d expected 0/0", hc_b, vc_b); end
    #2;
    rst_b = 1'b0;
    step();
    n_checks++; if (tick_b !== 1'b0) begin n_fail++; $display("FAIL post_rst_early: got %b expected 0", tick_b); end
    step();
    n_checks++; if (flags_b !== 6'b111111) begin n_fail++; $display("FAIL post_rst_start: got %b expected %b", flags_b, 6'b111111); end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_line();
    test_enable_drop();
    test_small_frame();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
